// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcode, state and control-encoding definitions for the MIPS core
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_OR   = 6'b100101;
   localparam logic [5:0] FN_SLT  = 6'b101010;

   typedef enum logic [3:0] {
      S_FETCH, S_DCD, S_EXE, S_AWB, S_MADR, S_MRD, S_MWB, S_MWR, S_BR, S_TRAP
   } state_t;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_OR    = 3'b010;
   localparam logic [2:0] ALU_SLT   = 3'b011;
   localparam logic [2:0] ALU_PASSB = 3'b100;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_HIGH = 2'b10;

   localparam logic [1:0] NPC_PC4 = 2'b00;
   localparam logic [1:0] NPC_BR  = 2'b01;
   localparam logic [1:0] NPC_J   = 2'b10;

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_DM  = 2'b01;
   localparam logic [1:0] WD_PC  = 2'b10;

   localparam logic [1:0] A3_RT  = 2'b00;
   localparam logic [1:0] A3_RD  = 2'b01;
   localparam logic [1:0] A3_R31 = 2'b10;

   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_ILL  = 2'b01;
   localparam logic [1:0] CAUSE_TMO  = 2'b10;

   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
      logic ok;
      ok = 1'b0;
      case (op)
         OP_RTYPE: ok = (funct == FN_ADDU) || (funct == FN_SUBU) ||
                        (funct == FN_OR)   || (funct == FN_SLT);
         OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/wait_timer.sv
// rtl/wait_timer.sv - memory wait counter; flags a timeout once WAIT_LIMIT idle cycles have elapsed
module wait_timer #(
   parameter int WAIT_LIMIT = 16,
   parameter int WCNT_W     = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic rdy,
   output logic timeout
);

   logic [WCNT_W-1:0] cnt;

   // ready in the limit cycle still completes the access
   assign timeout = (WAIT_LIMIT != 0) && active && !rdy &&
                    (cnt == WCNT_W'(WAIT_LIMIT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (!active || rdy)
         cnt <= '0;
      else if (!timeout)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM with memory handshakes and timeout trap
module mc_ctrl
   import mips_pkg::*;
#(
   parameter int WAIT_LIMIT = 16,
   parameter int WCNT_W     = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       im_rdy,
   input  logic       dm_rdy,
   output logic       im_req,
   output logic       dm_req,
   output logic       PCWr,
   output logic       IRWr,
   output logic       RFWr,
   output logic       DMWr,
   output logic [1:0] EXTOp,
   output logic [2:0] ALUOp,
   output logic [1:0] NPCOp,
   output logic       BSel,
   output logic [1:0] WDSel,
   output logic [1:0] A3Sel,
   output logic       trap,
   output logic [1:0] cause
);

   state_t     state, next;
   logic [1:0] cause_q;
   logic       wt_active, wt_rdy, tmo;

   assign wt_active = (state == S_FETCH) || (state == S_MRD) || (state == S_MWR);
   assign wt_rdy    = (state == S_FETCH) ? im_rdy : dm_rdy;

   wait_timer #(.WAIT_LIMIT(WAIT_LIMIT), .WCNT_W(WCNT_W)) u_wait_timer (
      .clk     (clk),
      .rst     (rst),
      .active  (wt_active),
      .rdy     (wt_rdy),
      .timeout (tmo)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_FETCH;
         cause_q <= CAUSE_NONE;
      end else begin
         state <= next;
         if (state != S_TRAP && next == S_TRAP)
            cause_q <= (state == S_DCD) ? CAUSE_ILL : CAUSE_TMO;
      end
   end

   always_comb begin
      next = state;
      case (state)
         S_FETCH: if (im_rdy) next = S_DCD; else if (tmo) next = S_TRAP;
         S_DCD: begin
            if (!is_legal(op, funct))
               next = S_TRAP;
            else if (op == OP_J || op == OP_JAL)
               next = S_FETCH;
            else if (op == OP_BEQ)
               next = S_BR;
            else if (op == OP_LW || op == OP_SW)
               next = S_MADR;
            else
               next = S_EXE;
         end
         S_EXE:   next = S_AWB;
         S_AWB:   next = S_FETCH;
         S_MADR:  next = (op == OP_LW) ? S_MRD : S_MWR;
         S_MRD:   if (dm_rdy) next = S_MWB; else if (tmo) next = S_TRAP;
         S_MWB:   next = S_FETCH;
         S_MWR:   if (dm_rdy) next = S_FETCH; else if (tmo) next = S_TRAP;
         S_BR:    next = S_FETCH;
         S_TRAP:  next = S_TRAP;
         default: next = S_FETCH;
      endcase
   end

   assign trap  = (state == S_TRAP);
   assign cause = cause_q;

   // everything is held low while rst is asserted so an aborted instruction writes nothing
   always_comb begin
      im_req = 1'b0;
      dm_req = 1'b0;
      PCWr   = 1'b0;
      IRWr   = 1'b0;
      RFWr   = 1'b0;
      DMWr   = 1'b0;
      EXTOp  = EXT_ZERO;
      ALUOp  = ALU_ADD;
      NPCOp  = NPC_PC4;
      BSel   = 1'b0;
      WDSel  = WD_ALU;
      A3Sel  = A3_RT;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               im_req = 1'b1;
               IRWr   = im_rdy;
               PCWr   = im_rdy;
            end
            S_DCD: begin
               if (op == OP_J || op == OP_JAL) begin
                  PCWr  = 1'b1;
                  NPCOp = NPC_J;
               end
               if (op == OP_JAL) begin
                  RFWr  = 1'b1;
                  A3Sel = A3_R31;
                  WDSel = WD_PC;
               end
            end
            S_EXE: begin
               if (op == OP_ORI) begin
                  ALUOp = ALU_OR;
                  BSel  = 1'b1;
                  EXTOp = EXT_ZERO;
               end else if (op == OP_LUI) begin
                  ALUOp = ALU_PASSB;
                  BSel  = 1'b1;
                  EXTOp = EXT_HIGH;
               end else begin
                  case (funct)
                     FN_SUBU: ALUOp = ALU_SUB;
                     FN_OR:   ALUOp = ALU_OR;
                     FN_SLT:  ALUOp = ALU_SLT;
                     default: ALUOp = ALU_ADD;
                  endcase
               end
            end
            S_AWB: begin
               RFWr  = 1'b1;
               A3Sel = (op == OP_RTYPE) ? A3_RD : A3_RT;
            end
            S_MADR: begin
               ALUOp = ALU_ADD;
               BSel  = 1'b1;
               EXTOp = EXT_SIGN;
            end
            S_MRD: dm_req = 1'b1;
            S_MWB: begin
               RFWr  = 1'b1;
               WDSel = WD_DM;
            end
            S_MWR: begin
               dm_req = 1'b1;
               DMWr   = !tmo;
            end
            S_BR: begin
               ALUOp = ALU_SUB;
               EXTOp = EXT_SIGN;
               NPCOp = NPC_BR;
               PCWr  = zero;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - randomized trace-model bench for mc_ctrl
module tb_mc_ctrl;

   localparam int LIM = 4;

   typedef struct packed {
      logic       im_req, dm_req, pcwr, irwr, rfwr, dmwr;
      logic [1:0] ext;
      logic [2:0] alu;
      logic [1:0] npc;
      logic       bsel;
      logic [1:0] wdsel, a3sel;
      logic       trap;
      logic [1:0] cause;
   } ctl_t;

   typedef struct {
      logic       ir, dr, zr;
      logic [5:0] opv, fnv;
      ctl_t       exp, msk;
      int         ph;
   } cyc_t;

   logic       clk = 1'b0, rst = 1'b1;
   logic [5:0] op = '0, funct = '0;
   logic       zero = 1'b0, im_rdy = 1'b0, dm_rdy = 1'b0;
   logic       im_req, dm_req, PCWr, IRWr, RFWr, DMWr, BSel, trap;
   logic [1:0] EXTOp, NPCOp, WDSel, A3Sel, cause;
   logic [2:0] ALUOp;
   ctl_t       obs;

   int   n_checks = 0, n_fail = 0, instr_no = 0;
   cyc_t trace[$];
   string ph_name[10] = '{"FETCH", "DCD", "EXE", "AWB", "MADR", "MRD", "MWB", "MWR", "BR", "TRAP"};

   logic [5:0] t_op[11] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b001101, 6'b001111,
                            6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b000011};
   logic [5:0] t_fn[11] = '{6'b100001, 6'b100011, 6'b100101, 6'b101010, 6'b0, 6'b0,
                            6'b0, 6'b0, 6'b0, 6'b0, 6'b0};

   mc_ctrl #(.WAIT_LIMIT(LIM), .WCNT_W(3)) dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .im_rdy(im_rdy), .dm_rdy(dm_rdy), .im_req(im_req), .dm_req(dm_req),
      .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr), .EXTOp(EXTOp),
      .ALUOp(ALUOp), .NPCOp(NPCOp), .BSel(BSel), .WDSel(WDSel), .A3Sel(A3Sel),
      .trap(trap), .cause(cause)
   );

   assign obs = {im_req, dm_req, PCWr, IRWr, RFWr, DMWr, EXTOp, ALUOp, NPCOp,
                 BSel, WDSel, A3Sel, trap, cause};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // 0 illegal, 1 R, 2 ori, 3 lui, 4 lw, 5 sw, 6 beq, 7 j, 8 jal
   function automatic int classify(input logic [5:0] o, input logic [5:0] f);
      case (o)
         6'b000000: return (f == 6'b100001 || f == 6'b100011 ||
                            f == 6'b100101 || f == 6'b101010) ? 1 : 0;
         6'b001101: return 2;
         6'b001111: return 3;
         6'b100011: return 4;
         6'b101011: return 5;
         6'b000100: return 6;
         6'b000010: return 7;
         6'b000011: return 8;
         default:   return 0;
      endcase
   endfunction

   task automatic push(input logic ir, input logic dr, input logic zr, input logic [5:0] o,
                       input logic [5:0] f, input ctl_t e, input ctl_t m, input int ph);
      cyc_t c;
      c.ir = ir; c.dr = dr; c.zr = zr; c.opv = o; c.fnv = f;
      c.exp = e; c.msk = m; c.ph = ph;
      trace.push_back(c);
   endtask

   task automatic add_trap(input logic [1:0] cs, input logic zr, input logic [5:0] o,
                           input logic [5:0] f);
      ctl_t e;
      for (int i = 0; i < 3; i++) begin
         e = '0; e.trap = 1'b1; e.cause = cs;
         push(1'($urandom), 1'($urandom), zr, o, f, e, '1, 9);
      end
   endtask

   // data memory phase; returns 1 when the access times out
   task automatic add_mem(input int dw, input logic wr, input logic zr, input logic [5:0] o,
                          input logic [5:0] f, output logic trapped);
      ctl_t e, m;
      int   n;
      int   ph;
      ph = wr ? 7 : 5;
      n = (dw > LIM) ? LIM : dw;
      trapped = 1'b0;
      for (int i = 0; i < n; i++) begin
         e = '0; e.dm_req = 1'b1; e.dmwr = wr;
         push(1'($urandom), 1'b0, zr, o, f, e, '1, ph);
      end
      if (dw > LIM) begin
         e = '0; m = '1; m.dm_req = 1'b0;
         push(1'($urandom), 1'b0, zr, o, f, e, m, ph);
         add_trap(2'b10, zr, o, f);
         trapped = 1'b1;
      end else begin
         e = '0; e.dm_req = 1'b1; e.dmwr = wr;
         push(1'($urandom), 1'b1, zr, o, f, e, '1, ph);
      end
   endtask

   // expected cycle-by-cycle behaviour of one instruction
   task automatic build(input logic [5:0] o, input logic [5:0] f, input logic zr,
                        input int iw, input int dw, output logic trapped);
      ctl_t e, m;
      int   n, cls;
      logic t;
      trapped = 1'b0;
      n = (iw > LIM) ? LIM : iw;
      for (int i = 0; i < n; i++) begin
         e = '0; e.im_req = 1'b1;
         push(1'b0, 1'($urandom), zr, 6'($urandom), 6'($urandom), e, '1, 0);
      end
      if (iw > LIM) begin
         e = '0; m = '1; m.im_req = 1'b0;
         push(1'b0, 1'($urandom), zr, 6'($urandom), 6'($urandom), e, m, 0);
         add_trap(2'b10, zr, o, f);
         trapped = 1'b1;
         return;
      end
      e = '0; e.im_req = 1'b1; e.irwr = 1'b1; e.pcwr = 1'b1;
      push(1'b1, 1'($urandom), zr, 6'($urandom), 6'($urandom), e, '1, 0);

      cls = classify(o, f);
      e = '0;
      if (cls == 7 || cls == 8) begin
         e.pcwr = 1'b1; e.npc = 2'b10;
      end
      if (cls == 8) begin
         e.rfwr = 1'b1; e.a3sel = 2'b10; e.wdsel = 2'b10;
      end
      push(1'($urandom), 1'($urandom), zr, o, f, e, '1, 1);

      case (cls)
         0: begin
            add_trap(2'b01, zr, o, f);
            trapped = 1'b1;
         end
         1, 2, 3: begin
            e = '0; m = '1;
            if (cls == 1) e.alu = (f == 6'b100001) ? 3'd0 : (f == 6'b100011) ? 3'd1 :
                                  (f == 6'b100101) ? 3'd2 : 3'd3;
            if (cls == 2) begin e.alu = 3'd2; e.bsel = 1'b1; e.ext = 2'b00; end
            if (cls == 3) begin e.alu = 3'd4; e.ext = 2'b10; m.bsel = 1'b0; end
            push(1'($urandom), 1'($urandom), zr, o, f, e, m, 2);
            e = '0; e.rfwr = 1'b1; e.a3sel = (cls == 1) ? 2'b01 : 2'b00;
            push(1'($urandom), 1'($urandom), zr, o, f, e, '1, 3);
         end
         4, 5: begin
            e = '0; e.alu = 3'd0; e.bsel = 1'b1; e.ext = 2'b01;
            push(1'($urandom), 1'($urandom), zr, o, f, e, '1, 4);
            add_mem(dw, cls == 5, zr, o, f, t);
            trapped = t;
            if (cls == 4 && !t) begin
               e = '0; e.rfwr = 1'b1; e.wdsel = 2'b01;
               push(1'($urandom), 1'($urandom), zr, o, f, e, '1, 6);
            end
         end
         6: begin
            e = '0; e.alu = 3'd1; e.ext = 2'b01; e.npc = 2'b01; e.pcwr = zr;
            push(1'($urandom), 1'($urandom), zr, o, f, e, '1, 8);
         end
         default: ;
      endcase
   endtask

   task automatic run_trace(input int limit);
      cyc_t c;
      for (int i = 0; i < trace.size() && i < limit; i++) begin
         c = trace[i];
         im_rdy = c.ir; dm_rdy = c.dr; zero = c.zr; op = c.opv; funct = c.fnv;
         @(negedge clk);
         check($sformatf("i%0d.%s.c%0d", instr_no, ph_name[c.ph], i), obs & c.msk, c.exp & c.msk);
         @(posedge clk);
         #1;
      end
      trace.delete();
      instr_no++;
   endtask

   task automatic do_reset();
      ctl_t m;
      m = '0; m.pcwr = 1'b1; m.irwr = 1'b1; m.rfwr = 1'b1; m.dmwr = 1'b1;
      m.trap = 1'b1; m.cause = 2'b11;
      rst = 1'b1; im_rdy = 1'b1; dm_rdy = 1'b1; zero = 1'b1;
      #2;
      check("reset_strobes", obs & m, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic zr,
                           input int iw, input int dw);
      logic t;
      build(o, f, zr, iw, dw, t);
      run_trace(trace.size());
      if (t) do_reset();
   endtask

   initial begin
      int   k, sel, kind;
      logic [5:0] o, f;
      logic t;
      @(posedge clk);
      #1;
      do_reset();

      do_instr(6'b000000, 6'b100001, 1'b0, 0, 0);
      do_instr(6'b100011, 6'b000000, 1'b0, 0, 3);
      do_instr(6'b000100, 6'b000000, 1'b1, 0, 0);
      do_instr(6'b000100, 6'b000000, 1'b0, 1, 0);
      do_instr(6'b000011, 6'b000000, 1'b0, 0, 0);
      do_instr(6'b000010, 6'b000000, 1'b0, 2, 0);
      do_instr(6'b001101, 6'b010101, 1'b0, 0, 0);
      do_instr(6'b001111, 6'b000000, 1'b0, LIM, 0);
      do_instr(6'b101011, 6'b000000, 1'b0, 0, LIM);
      do_instr(6'b101011, 6'b000000, 1'b0, 0, LIM + 1);
      do_instr(6'b111111, 6'b000000, 1'b0, 0, 0);
      do_instr(6'b000000, 6'b111111, 1'b0, 0, 0);
      do_instr(6'b000000, 6'b101010, 1'b0, LIM + 1, 0);
      do_instr(6'b100011, 6'b000000, 1'b0, 0, LIM + 1);

      for (int n = 0; n < 150; n++) begin
         sel  = $urandom_range(0, 10);
         o    = t_op[sel];
         f    = (sel < 4) ? t_fn[sel] : 6'($urandom);
         kind = $urandom_range(0, 19);
         if (kind <= 15) begin
            do_instr(o, f, 1'($urandom), $urandom_range(0, LIM), $urandom_range(0, LIM));
         end else if (kind <= 17) begin
            do begin
               o = 6'($urandom); f = 6'($urandom);
            end while (classify(o, f) != 0);
            do_instr(o, f, 1'($urandom), $urandom_range(0, LIM), 0);
         end else if (kind == 18) begin
            if ($urandom_range(0, 1) == 0)
               do_instr(o, f, 1'($urandom), LIM + 1, 0);
            else
               do_instr(($urandom_range(0, 1) == 0) ? 6'b100011 : 6'b101011, f,
                        1'($urandom), 0, LIM + 1);
         end else begin
            build(o, f, 1'($urandom), $urandom_range(0, LIM), $urandom_range(0, LIM), t);
            k = $urandom_range(1, trace.size() - 1);
            run_trace(k);
            do_reset();
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
